// File: rtl/bios_loader_if.sv
// Port bundle for bios_loader: the hps_io ioctl download stream plus the
// system BIOS word-write port. The loader uses the slave view.
interface bios_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;

  logic [12:0] bios_addr;
  logic [15:0] bios_din;
  logic        bios_wr;
  logic        bios_req;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, bios_req,
    input  ioctl_wait, bios_addr, bios_din, bios_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, bios_req,
    output ioctl_wait, bios_addr, bios_din, bios_wr
  );
endinterface

// File: rtl/bios_loader.sv
// Packs the ioctl byte stream into little-endian 16-bit words, buffers them
// in a small FIFO and drains them into the BIOS port; bios_loaded marks completion.
module bios_loader #(
  parameter int         WORDS      = 8192,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] BIOS_INDEX = 8'h00
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  bios_loader_if.slave bus,
  output logic         bios_loaded,
  output logic         overflow,
  output logic [13:0]  word_count
);
  localparam int AW = $clog2(WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [24:0]   BYTE_LIMIT = 25'(2 * WORDS);
  localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 2);
  localparam logic [13:0]   COUNT_MAX  = 14'(WORDS);

  typedef enum logic [1:0] { IDLE, LOAD, FLUSH, DONE } state_t;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [15:0]   data;
  } entry_t;

  state_t        state, state_next;
  logic          active, active_q, start, stop, restart, take_byte;
  logic [AW-1:0] byte_wa;
  logic [7:0]    byte_data;

  logic          pend_valid, pend_valid_next;
  logic [AW-1:0] pend_wa, pend_wa_next;
  logic [7:0]    pend_lo, pend_lo_next;

  logic          push_a, push_b, drop;
  logic [1:0]    n_push;
  entry_t        entry_a, entry_b;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          pop, xfer;

  logic          out_wr;
  entry_t        out_entry;

  assign active    = bus.ioctl_download && (bus.ioctl_index == BIOS_INDEX);
  assign start     = active && !active_q;
  assign stop      = active_q && !active;
  assign restart   = start && ((state == IDLE) || (state == DONE));
  assign take_byte = (state == LOAD) && active && bus.ioctl_wr;
  assign byte_wa   = bus.ioctl_addr[AW:1];
  assign byte_data = bus.ioctl_dout;

  // FSM next-state logic.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (stop) state_next = FLUSH;
      FLUSH:   if ((fifo_count == '0) && !out_wr) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Byte packing: up to two FIFO pushes per byte, the older padded word first.
  always_comb begin
    pend_valid_next = pend_valid;
    pend_wa_next    = pend_wa;
    pend_lo_next    = pend_lo;
    push_a          = 1'b0;
    push_b          = 1'b0;
    drop            = 1'b0;
    entry_a         = '0;
    entry_b         = '0;

    if (restart) begin
      pend_valid_next = 1'b0;
    end else if (take_byte) begin
      if (bus.ioctl_addr >= BYTE_LIMIT) begin
        drop = 1'b1;
      end else if (!bus.ioctl_addr[0]) begin
        push_a          = pend_valid;
        entry_a         = {pend_wa, 8'h00, pend_lo};
        pend_valid_next = 1'b1;
        pend_wa_next    = byte_wa;
        pend_lo_next    = byte_data;
      end else begin
        pend_valid_next = 1'b0;
        push_a          = 1'b1;
        if (pend_valid && (pend_wa == byte_wa)) begin
          entry_a = {byte_wa, byte_data, pend_lo};
        end else if (pend_valid) begin
          entry_a = {pend_wa, 8'h00, pend_lo};
          push_b  = 1'b1;
          entry_b = {byte_wa, byte_data, 8'h00};
        end else begin
          entry_a = {byte_wa, byte_data, 8'h00};
        end
      end
    end else if ((state == LOAD) && stop && pend_valid) begin
      push_a          = 1'b1;
      entry_a         = {pend_wa, 8'h00, pend_lo};
      pend_valid_next = 1'b0;
    end
  end

  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign xfer   = out_wr && bus.bios_req;
  assign pop    = (fifo_count != '0) && (!out_wr || bus.bios_req);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      active_q   <= 1'b0;
      pend_valid <= 1'b0;
      pend_wa    <= '0;
      pend_lo    <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_next;
      active_q   <= active;
      pend_valid <= pend_valid_next;
      pend_wa    <= pend_wa_next;
      pend_lo    <= pend_lo_next;
      if (restart) begin
        overflow   <= 1'b0;
        word_count <= '0;
      end else begin
        if (drop) overflow <= 1'b1;
        if (xfer && (word_count != COUNT_MAX)) word_count <= word_count + 14'd1;
      end
    end
  end

  // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (push_a) mem[wr_ptr] <= entry_a;
    if (push_b) mem[wr_ptr + 1'b1] <= entry_b;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_wr     <= 1'b0;
      out_entry  <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(n_push);
      fifo_count <= fifo_count + CW'(n_push) - CW'(pop);
      if (pop) begin
        out_wr    <= 1'b1;
        out_entry <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (xfer) begin
        out_wr <= 1'b0;
      end
    end
  end

  // Headroom of two entries covers an odd byte that flushes a stale pending byte.
  assign bus.ioctl_wait = active && (fifo_count >= WAIT_LEVEL);
  assign bus.bios_wr    = out_wr;
  assign bus.bios_addr  = out_entry.wa;
  assign bus.bios_din   = out_entry.data;
  assign bios_loaded    = (state == DONE);
endmodule

// File: tb/tb_bios_loader.sv
// Directed self-checking bench for bios_loader: full loads, stall, odd length,
// overflow, foreign index, empty download and mid-load reset.
module tb_bios_loader;
  localparam int WORDS      = 8192;
  localparam int FIFO_DEPTH = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        bios_loaded;
  logic        overflow;
  logic [13:0] word_count;

  bios_loader_if bus();

  bios_loader #(
    .WORDS      (WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BIOS_INDEX (8'h00)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .bus         (bus),
    .bios_loaded (bios_loaded),
    .overflow    (overflow),
    .word_count  (word_count)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [28:0] exp_q[$];
  logic        stall_q    = 1'b0;
  logic [28:0] stall_word = '0;
  logic        full_push  = 1'b0;
  logic        wait_seen  = 1'b0;
  int          wait_depth = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfer monitor: samples on the falling edge, ahead of the rising edge that completes it.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (stall_q) begin
        check("stall_wr_held", 32'(bus.bios_wr), 32'd1);
        check("stall_word_held", 32'({bus.bios_addr, bus.bios_din}), 32'(stall_word));
      end
      if (bus.bios_wr && bus.bios_req) begin
        if (exp_q.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
        else check("word", 32'({bus.bios_addr, bus.bios_din}), 32'(exp_q.pop_front()));
      end
      stall_q    = bus.bios_wr && !bus.bios_req;
      stall_word = {bus.bios_addr, bus.bios_din};
      if (dut.fifo_count > FIFO_DEPTH) full_push = 1'b1;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int guard = 0;
    while (bus.ioctl_wait && guard < 1000) begin
      if (!wait_seen) begin
        wait_seen  = 1'b1;
        wait_depth = exp_q.size();
      end
      tick();
      guard++;
    end
    if (guard >= 1000) check("wait_timeout", 32'd1, 32'd0);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic end_dl(input int bound, input string tag);
    int n = 0;
    bus.ioctl_download = 1'b0;
    while (!bios_loaded && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(bios_loaded), 32'd1);
  endtask

  task automatic full_load(input string tag);
    start_dl(8'h00);
    for (int i = 0; i < 2 * WORDS; i++) begin
      logic [24:0] a;
      a = 25'(i);
      if (a[0]) exp_q.push_back({a[13:1], a[7:0], 8'(a[7:0] - 8'd1)});
      send_byte(a, a[7:0]);
    end
    end_dl(FIFO_DEPTH + 3, {tag, "_loaded"});
    check({tag, "_count"}, 32'(word_count), 32'(WORDS));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev;
    logic [7:0] d;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = 8'h00;
    bus.bios_req       = 1'b1;

    // Reset state
    #23;
    check("rst_wr", 32'(bus.bios_wr), 32'd0);
    check("rst_loaded", 32'(bios_loaded), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Sequential full image with bios_req tied high
    wait_seen = 1'b0;
    full_load("seq");
    check("seq_no_wait", 32'(wait_seen), 32'd0);
    check("seq_no_overflow", 32'(overflow), 32'd0);

    // Output stalled for 100 cycles while bytes stream in
    bus.bios_req = 1'b0;
    wait_seen    = 1'b0;
    start_dl(8'h00);
    check("restart_clears_loaded", 32'(bios_loaded), 32'd0);
    fork
      begin
        repeat (100) @(posedge clk_sys);
        #1;
        bus.bios_req = 1'b1;
      end
    join_none
    prev = '0;
    for (int i = 0; i < 64; i++) begin
      d = 8'(i * 7 + 3);
      if (i % 2 == 1) exp_q.push_back({13'(i / 2), d, prev});
      send_byte(25'(i), d);
      prev = d;
    end
    end_dl(200, "stall_loaded");
    check("stall_wait_seen", 32'(wait_seen), 32'd1);
    check("stall_wait_depth", 32'(wait_depth), 32'd15);
    check("stall_count", 32'(word_count), 32'd32);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Odd-length image AA BB CC DD EE, with first-word latency
    start_dl(8'h00);
    send_byte(25'd0, 8'hAA);
    exp_q.push_back({13'd0, 16'hBBAA});
    send_byte(25'd1, 8'hBB);
    check("lat_cycle1", 32'(bus.bios_wr), 32'd0);
    tick();
    check("lat_cycle2", 32'(bus.bios_wr), 32'd1);
    exp_q.push_back({13'd1, 16'hDDCC});
    exp_q.push_back({13'd2, 16'h00EE});
    send_byte(25'd2, 8'hCC);
    send_byte(25'd3, 8'hDD);
    send_byte(25'd4, 8'hEE);
    end_dl(FIFO_DEPTH + 3, "odd_loaded");
    check("odd_count", 32'(word_count), 32'd3);
    check("odd_drained", 32'(exp_q.size()), 32'd0);

    // Byte beyond the image is dropped
    start_dl(8'h00);
    exp_q.push_back({13'd0, 16'h2211});
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd16384, 8'h33);
    end_dl(FIFO_DEPTH + 3, "ovf_loaded");
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(word_count), 32'd1);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // Foreign index is ignored entirely
    start_dl(8'h01);
    for (int i = 0; i < 4; i++) begin
      send_byte(25'(i), 8'(8'h40 + i));
      check("idx_wait", 32'(bus.ioctl_wait), 32'd0);
    end
    bus.ioctl_download = 1'b0;
    repeat (5) tick();
    bus.ioctl_index = 8'h00;
    check("idx_loaded", 32'(bios_loaded), 32'd1);
    check("idx_count", 32'(word_count), 32'd1);
    check("idx_overflow", 32'(overflow), 32'd1);

    // Zero-byte download still completes
    start_dl(8'h00);
    check("empty_clears_loaded", 32'(bios_loaded), 32'd0);
    check("empty_clears_overflow", 32'(overflow), 32'd0);
    end_dl(FIFO_DEPTH + 3, "empty_loaded");
    check("empty_count", 32'(word_count), 32'd0);

    // Reset mid-load, then a full reload
    start_dl(8'h00);
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 1) exp_q.push_back({13'(i / 2), 8'(i), 8'(i - 1)});
      send_byte(25'(i), 8'(i));
    end
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    bus.ioctl_download = 1'b0;
    check("midrst_wr", 32'(bus.bios_wr), 32'd0);
    check("midrst_addr", 32'(bus.bios_addr), 32'd0);
    check("midrst_din", 32'(bus.bios_din), 32'd0);
    check("midrst_loaded", 32'(bios_loaded), 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    check("midrst_wait", 32'(bus.ioctl_wait), 32'd0);
    repeat (3) tick();
    check("midrst_held_wr", 32'(bus.bios_wr), 32'd0);
    reset_n = 1'b1;
    tick();
    full_load("reload");

    check("no_push_into_full", 32'(full_push), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
